oam_dma: RTL and testbench

OAM DMA controller: the bus-initiator counterpart to the memory-mapped responders on the CPU bus (cartridge ROM/RAM, WRAM). A CPU write to FF46 latches a source page. The block then takes the bus and copies 160 bytes from `{page, 8'h00}` into OAM, one byte per M-cycle. It sits beside the CPU bus decoder and drives the OAM write port directly.

---
 rtl/gb_pkg.sv | 19 +
 rtl/oam_dma.sv | 107 ++++++++++
 tb/tb_oam_dma.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the Game Boy CPU-bus side blocks.
// Holds the OAM DMA register address, transfer length and controller state type.
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int unsigned OAM_BYTES    = 160;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_t;

    // E0-FF is the WRAM echo region; a DMA from there really reads C0-DF.
    function automatic logic [7:0] effective_page(input logic [7:0] src);
        return (src >= 8'hE0) ? (src & 8'hDF) : src;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA controller: a write to the source register copies OAM_BYTES bytes
// from {page, 00} into OAM, one byte per M-cycle tick.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = gb_pkg::DMA_REG_ADDR,
    parameter int unsigned OAM_BYTES = gb_pkg::OAM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic [7:0]  reg_rdata,
    output logic        dma_active,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write
);

    import gb_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic       write_prev_q, write_prev_d;
    logic       active_q, active_d;
    logic       reg_write;
    logic [7:0] page;

    // A level write strobe held for several clocks is one register write.
    assign reg_write = cpu_write & ~write_prev_q & (cpu_addr == REG_ADDR);
    assign page      = effective_page(src_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            src_q        <= 8'h00;
            idx_q        <= 8'h00;
            write_prev_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            idx_q        <= idx_d;
            write_prev_q <= write_prev_d;
            active_q     <= active_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        idx_d        = idx_q;
        active_d     = active_q;
        write_prev_d = cpu_write;
        oam_write    = 1'b0;

        // A register write beats a coincident tick; a restart from a running
        // transfer keeps the bus so the CPU never sees it released.
        if (reg_write) begin
            src_d    = cpu_wdata;
            idx_d    = 8'h00;
            state_d  = START;
            active_d = (state_q == XFER) || ((state_q == START) && active_q);
        end else begin
            unique case (state_q)
                IDLE: begin
                    active_d = 1'b0;
                end
                START: begin
                    if (tick) begin
                        state_d  = XFER;
                        active_d = 1'b1;
                    end
                end
                XFER: begin
                    if (tick) begin
                        oam_write = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d  = IDLE;
                            idx_d    = 8'h00;
                            active_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    idx_d    = 8'h00;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    assign reg_rdata  = src_q;
    assign dma_active = active_q;
    assign bus_addr   = {page, idx_q};
    assign oam_addr   = idx_q;
    assign oam_wdata  = bus_rdata;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: register decode table, hand-written
// restart/reset/held-write sequences and randomized transfers against a model.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic        tick;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic [7:0]  reg_rdata;
    logic        dma_active;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_write;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam_mem [0:255];
    logic [7:0]  wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [15:0] wr_bus_q[$];

    int total = 0;
    int bad = 0;
    int tick_count = 0;
    int active_ticks = 0;
    int first_write_tick = -1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic [7:0]  exp_rdata;
        logic        exp_active;
        logic [15:0] exp_bus;
        int          exp_writes;
    } vec_t;

    vec_t vecs[10];

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .reg_rdata  (reg_rdata),
        .dma_active (dma_active),
        .bus_addr   (bus_addr),
        .bus_rdata  (bus_rdata),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .oam_write  (oam_write)
    );

    assign bus_rdata = mem[bus_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture OAM traffic one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (tick) begin
            tick_count++;
            if (dma_active) active_ticks++;
        end
        if (oam_write) begin
            wr_addr_q.push_back(oam_addr);
            wr_data_q.push_back(oam_wdata);
            wr_bus_q.push_back(bus_addr);
            oam_mem[oam_addr] = oam_wdata;
            if (first_write_tick < 0) first_write_tick = tick_count;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic wr);
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_write = wr;
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic doTick(input int gap);
        int g;
        g = (gap == 0) ? int'($urandom_range(3, 1)) : gap;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (g - 1) @(negedge clk);
    endtask

    task automatic drain(input string name, input int gap);
        int n;
        n = 1;
        doTick(gap);
        while (dma_active && n < 400) begin
            doTick(gap);
            n++;
        end
        checkOutput({name, "_idle"}, 32'(dma_active), 32'd0);
    endtask

    task automatic clearLog();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_bus_q.delete();
    endtask

    // Reference: a transfer from src copies bytes 0..159 of page src, with the
    // echo range E0-FF folded down by 0x20 onto C0-DF.
    task automatic checkTransfer(input string name, input logic [7:0] src);
        logic [7:0] pg;
        int errs;
        pg = (src >= 8'hE0) ? src - 8'h20 : src;
        errs = 0;
        checkOutput({name, "_count"}, 32'(wr_addr_q.size()), 32'd160);
        for (int i = 0; i < wr_addr_q.size() && i < 160; i++) begin
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== mem[{pg, 8'(i)}] ||
                wr_bus_q[i] !== {pg, 8'(i)}) begin
                if (errs == 0)
                    $display("[TB] %s first bad byte %0d: addr=%h data=%h bus=%h", name, i,
                             wr_addr_q[i], wr_data_q[i], wr_bus_q[i]);
                errs++;
            end
        end
        checkOutput({name, "_bytes"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int n;
        int errs;
        logic [7:0] src;

        reset     = 1'b0;
        tick      = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_write = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

        #1;
        checkOutput("reset_active", 32'(dma_active), 32'd0);
        checkOutput("reset_oam_write", 32'(oam_write), 32'd0);
        checkOutput("reset_bus_addr", 32'(bus_addr), 32'h0000);
        checkOutput("reset_rdata", 32'(reg_rdata), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        vecs[0] = '{16'hFF45, 8'h12, 1'b1, 8'h00, 1'b0, 16'h0000, 0};
        vecs[1] = '{16'hFF47, 8'h34, 1'b1, 8'h00, 1'b0, 16'h0000, 0};
        vecs[2] = '{16'hFF46, 8'h56, 1'b0, 8'h00, 1'b0, 16'h0000, 0};
        vecs[3] = '{16'hFF46, 8'hC1, 1'b1, 8'hC1, 1'b1, 16'hC100, 160};
        vecs[4] = '{16'hFF46, 8'hE3, 1'b1, 8'hE3, 1'b1, 16'hC300, 160};
        vecs[5] = '{16'hFF47, 8'h99, 1'b1, 8'hE3, 1'b0, 16'hC300, 0};
        vecs[6] = '{16'hFF46, 8'hFF, 1'b1, 8'hFF, 1'b1, 16'hDF00, 160};
        vecs[7] = '{16'hFF46, 8'h00, 1'b1, 8'h00, 1'b1, 16'h0000, 160};
        vecs[8] = '{16'hFF46, 8'hDF, 1'b1, 8'hDF, 1'b1, 16'hDF00, 160};
        vecs[9] = '{16'hFF46, 8'hE0, 1'b1, 8'hE0, 1'b1, 16'hC000, 160};

        for (int k = 0; k < 10; k++) begin
            clearLog();
            applyStimulus(vecs[k].addr, vecs[k].data, vecs[k].wr);
            doTick(1);
            #1;
            checkOutput($sformatf("vec%0d_rdata", k), 32'(reg_rdata), 32'(vecs[k].exp_rdata));
            checkOutput($sformatf("vec%0d_active", k), 32'(dma_active), 32'(vecs[k].exp_active));
            checkOutput($sformatf("vec%0d_bus", k), 32'(bus_addr), 32'(vecs[k].exp_bus));
            drain($sformatf("vec%0d", k), 1);
            if (vecs[k].exp_writes != 0)
                checkTransfer($sformatf("vec%0d", k), vecs[k].data);
            else
                checkOutput($sformatf("vec%0d_count", k), 32'(wr_addr_q.size()), 32'd0);
        end

        // Basic transfer, tick every 4 clocks.
        clearLog();
        for (int i = 0; i < 160; i++) oam_mem[i] = 8'h00;
        applyStimulus(16'hFF46, 8'hC1, 1'b1);
        tick_count = 0;
        active_ticks = 0;
        first_write_tick = -1;
        drain("basic", 4);
        checkTransfer("basic", 8'hC1);
        errs = 0;
        for (int i = 0; i < 160; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) errs++;
        checkOutput("basic_oam", 32'(errs), 32'd0);
        checkOutput("basic_active_ticks", 32'(active_ticks), 32'd160);
        checkOutput("basic_first_tick", 32'(first_write_tick), 32'd2);
        checkOutput("basic_total_ticks", 32'(tick_count), 32'd161);
        checkOutput("basic_rdata", 32'(reg_rdata), 32'hC1);

        // Write held high for 10 clocks while ticks run.
        clearLog();
        @(negedge clk);
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'h80;
        cpu_write = 1'b1;
        fork
            begin
                repeat (10) @(negedge clk);
                cpu_write = 1'b0;
            end
            repeat (5) doTick(1);
        join
        drain("held", 1);
        checkTransfer("held", 8'h80);
        checkOutput("held_first_bus", 32'((wr_bus_q.size() > 0) ? wr_bus_q[0] : 16'hFFFF), 32'h8000);

        // Restart at idx 50 with a coincident tick.
        clearLog();
        applyStimulus(16'hFF46, 8'hC1, 1'b1);
        n = 0;
        while (wr_addr_q.size() < 50 && n < 200) begin
            doTick(1);
            n++;
        end
        checkOutput("restart_reach", 32'(wr_addr_q.size()), 32'd50);
        @(negedge clk);
        tick      = 1'b1;
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'hC2;
        cpu_write = 1'b1;
        #4;
        checkOutput("restart_idx", 32'(oam_addr), 32'd50);
        checkOutput("restart_no_write", 32'(oam_write), 32'd0);
        @(negedge clk);
        tick      = 1'b0;
        cpu_write = 1'b0;
        #1;
        checkOutput("restart_active", 32'(dma_active), 32'd1);
        checkOutput("restart_bus", 32'(bus_addr), 32'hC200);
        checkOutput("restart_rdata", 32'(reg_rdata), 32'hC2);
        checkOutput("restart_log50", 32'(wr_addr_q.size()), 32'd50);
        clearLog();
        doTick(1);
        checkOutput("restart_startup_nowrite", 32'(wr_addr_q.size()), 32'd0);
        checkOutput("restart_startup_active", 32'(dma_active), 32'd1);
        drain("restart", 1);
        checkTransfer("restart", 8'hC2);

        // Asynchronous reset at idx 80.
        clearLog();
        applyStimulus(16'hFF46, 8'hC3, 1'b1);
        n = 0;
        while (wr_addr_q.size() < 80 && n < 200) begin
            doTick(2);
            n++;
        end
        checkOutput("rst_reach", 32'(wr_addr_q.size()), 32'd80);
        @(negedge clk);
        reset = 1'b0;
        tick  = 1'b1;
        #1;
        checkOutput("rst_active", 32'(dma_active), 32'd0);
        checkOutput("rst_oam_write", 32'(oam_write), 32'd0);
        checkOutput("rst_bus", 32'(bus_addr), 32'h0000);
        checkOutput("rst_rdata", 32'(reg_rdata), 32'h00);
        checkOutput("rst_oam_addr", 32'(oam_addr), 32'h00);
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clearLog();
        repeat (20) doTick(1);
        checkOutput("rst_no_writes", 32'(wr_addr_q.size()), 32'd0);
        checkOutput("rst_idle", 32'(dma_active), 32'd0);

        // Randomized transfers with random tick spacing.
        for (int r = 0; r < 5; r++) begin
            clearLog();
            src = 8'($urandom);
            applyStimulus(16'hFF46, src, 1'b1);
            drain($sformatf("rand%0d", r), 0);
            checkTransfer($sformatf("rand%0d", r), src);
            checkOutput($sformatf("rand%0d_rdata", r), 32'(reg_rdata), 32'(src));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
